// File: rtl/camera_qsys_gpio_seq_pkg.sv
// Shared definitions for the camera GPIO sequencer: register offsets,
// STATUS bit positions and the pulse FSM state encoding.
package camera_qsys_gpio_seq_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_PULSE  = 3'd3;
    localparam logic [2:0] ADDR_PLEN   = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR  = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/camera_qsys_gpio_pulse_timer.sv
// Pulse timer: down-counter with terminal-count compare.
//   state     | meaning
//   ST_IDLE   | no pulse running, waiting for start
//   ST_ACTIVE | pulse running, cnt holds cycles remaining (>=1)
module camera_qsys_gpio_pulse_timer
    import camera_qsys_gpio_seq_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done_pulse
);

    pulse_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // Pulse FSM: a zero length is stretched to one cycle; start is ignored while active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ACTIVE;
                        cnt_q   <= (len == '0) ? CNT_W'(1) : len;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    // High during the final active cycle so the done flag lands on the same edge busy drops.
    assign done_pulse = (state_q == ST_ACTIVE) && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/camera_qsys_gpio_seq.sv
// Avalon-MM output port with atomic set/clear, a hardware-timed pulse
// that inverts masked pins for PLEN cycles, and a completion interrupt.
module camera_qsys_gpio_seq
    import camera_qsys_gpio_seq_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               CNT_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] pmask_q, pmask_d;
    logic [CNT_W-1:0] plen_q, plen_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic wr;
    logic pulse_wr;
    logic start;
    logic busy;
    logic done_pulse;
    logic unused_wd;

    assign wr        = chipselect && !write_n;
    assign pulse_wr  = wr && (address == ADDR_PULSE);
    assign start     = pulse_wr && !busy;
    assign unused_wd = ^writedata;

    camera_qsys_gpio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .len        (plen_q),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    // Register file next-state; a completion outranks a simultaneous done clear.
    always_comb begin
        data_d   = data_q;
        pmask_d  = pmask_q;
        plen_d   = plen_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        err_d    = err_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_d   = writedata[WIDTH-1:0];
                ADDR_SET:    data_d   = data_q | writedata[WIDTH-1:0];
                ADDR_CLEAR:  data_d   = data_q & ~writedata[WIDTH-1:0];
                ADDR_PULSE:  begin
                    if (busy) err_d   = 1'b1;
                    else      pmask_d = writedata[WIDTH-1:0];
                end
                ADDR_PLEN:   plen_d   = writedata[CNT_W-1:0];
                ADDR_CTRL:   irq_en_d = writedata[0];
                ADDR_STATUS: begin
                    if (writedata[STATUS_DONE]) done_d = 1'b0;
                    if (writedata[STATUS_ERR])  err_d  = 1'b0;
                end
                default: ;
            endcase
        end
        if (done_pulse) done_d = 1'b1;
    end

    // Register file state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            pmask_q  <= '0;
            plen_q   <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            pmask_q  <= pmask_d;
            plen_q   <= plen_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Zero-wait-state read mux straight from the registers.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[WIDTH-1:0] = data_q;
            ADDR_PULSE:  readdata[WIDTH-1:0] = pmask_q;
            ADDR_PLEN:   readdata[CNT_W-1:0] = plen_q;
            ADDR_CTRL:   readdata[0]         = irq_en_q;
            ADDR_STATUS: begin
                readdata[STATUS_BUSY] = busy;
                readdata[STATUS_DONE] = done_q;
                readdata[STATUS_ERR]  = err_q;
            end
            default: readdata = '0;
        endcase
    end

    assign out_port = data_q ^ (busy ? pmask_q : '0);
    assign irq      = irq_en_q & done_q;

endmodule
